// File: rtl/div_unit_pipelined.sv
// Radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU. Ops are queued in an input FIFO.
// Results leave through a valid/ready writeback port that carries the instruction id and PC.
module div_unit_pipelined #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = 3,
  parameter int PC_W       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            reuse_result,
  input  logic [ID_W-1:0] id,
  input  logic [PC_W-1:0] pc,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_rd,
  output logic [ID_W-1:0] wb_id,
  output logic [PC_W-1:0] wb_pc,
  output logic            busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] ZERO = '0;
  localparam logic [XLEN-1:0] ONES = '1;

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_WB} state_t;

  // Signs are stripped before queueing, so the datapath only ever sees magnitudes.
  logic            w_signed, w_neg1, w_neg2, w_push, w_pop;
  logic [XLEN-1:0] w_mag1, w_mag2;

  assign w_signed = ~op[0];
  assign w_neg1   = w_signed & rs1[XLEN-1];
  assign w_neg2   = w_signed & rs2[XLEN-1];
  assign w_mag1   = w_neg1 ? (ZERO - rs1) : rs1;
  assign w_mag2   = w_neg2 ? (ZERO - rs2) : rs2;

  logic [XLEN-1:0]       r_f_dvd [FIFO_DEPTH];
  logic [XLEN-1:0]       r_f_dvs [FIFO_DEPTH];
  logic [ID_W-1:0]       r_f_id  [FIFO_DEPTH];
  logic [PC_W-1:0]       r_f_pc  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_f_rem, r_f_negq, r_f_negr, r_f_reuse;
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]        r_count;

  state_t          r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0] r_quo, r_rem, r_dvs, r_saved_q, r_saved_r, r_wb_rd;
  logic            r_is_rem, r_neg_q, r_neg_r, r_wb_valid;
  logic [ID_W-1:0] r_wb_id;
  logic [PC_W-1:0] r_wb_pc;

  assign issue_ready = (r_count != FULL_CNT);
  assign w_push      = issue_valid & issue_ready & ~flush;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
  assign busy        = (r_count != '0) || (r_state != S_IDLE);

  assign wb_valid = r_wb_valid;
  assign wb_rd    = r_wb_rd;
  assign wb_id    = r_wb_id;
  assign wb_pc    = r_wb_pc;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_f_dvd[r_wr_ptr]   <= w_mag1;
      r_f_dvs[r_wr_ptr]   <= w_mag2;
      r_f_id[r_wr_ptr]    <= id;
      r_f_pc[r_wr_ptr]    <= pc;
      r_f_rem[r_wr_ptr]   <= op[1];
      r_f_negq[r_wr_ptr]  <= w_signed & (rs1[XLEN-1] ^ rs2[XLEN-1]);
      r_f_negr[r_wr_ptr]  <= w_neg1;
      r_f_reuse[r_wr_ptr] <= reuse_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + (PTR_W+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (PTR_W+1)'(1);
    end
  end

  logic [XLEN-1:0] w_h_dvd, w_h_dvs;
  logic            w_h_rem, w_h_negq, w_h_negr, w_h_reuse;

  assign w_h_dvd   = r_f_dvd[r_rd_ptr];
  assign w_h_dvs   = r_f_dvs[r_rd_ptr];
  assign w_h_rem   = r_f_rem[r_rd_ptr];
  assign w_h_negq  = r_f_negq[r_rd_ptr];
  assign w_h_negr  = r_f_negr[r_rd_ptr];
  assign w_h_reuse = r_f_reuse[r_rd_ptr];

  // The dividend shifts out of r_quo from the top as the quotient bits shift in at the bottom.
  logic [XLEN:0]   w_shift;
  logic            w_ge;
  logic [XLEN-1:0] w_diff, w_rem_nx, w_quo_nx;

  assign w_shift  = {r_rem, r_quo[XLEN-1]};
  assign w_ge     = (w_shift >= {1'b0, r_dvs});
  assign w_diff   = w_shift[XLEN-1:0] - r_dvs;
  assign w_rem_nx = w_ge ? w_diff : w_shift[XLEN-1:0];
  assign w_quo_nx = {r_quo[XLEN-2:0], w_ge};

  function automatic logic [XLEN-1:0] f_result(input logic [XLEN-1:0] q, input logic [XLEN-1:0] r,
                                               input logic is_rem, input logic neg_q,
                                               input logic neg_r, input logic dvs_nz);
    logic [XLEN-1:0] v;
    logic            n;
    v = is_rem ? r : q;
    n = is_rem ? neg_r : (neg_q & dvs_nz);
    return n ? (ZERO - v) : v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_dvs      <= '0;
      r_saved_q  <= '0;
      r_saved_r  <= '0;
      r_is_rem   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_id    <= '0;
      r_wb_pc    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_pop) begin
          r_wb_id  <= r_f_id[r_rd_ptr];
          r_wb_pc  <= r_f_pc[r_rd_ptr];
          r_is_rem <= w_h_rem;
          r_neg_q  <= w_h_negq;
          r_neg_r  <= w_h_negr;
          r_dvs    <= w_h_dvs;
          if (w_h_reuse) begin
            r_wb_rd    <= f_result(r_saved_q, r_saved_r, w_h_rem, w_h_negq, w_h_negr,
                                   w_h_dvs != ZERO);
            r_wb_valid <= 1'b1;
            r_state    <= S_WB;
          end else if (w_h_dvs == ZERO) begin
            r_saved_q  <= ONES;
            r_saved_r  <= w_h_dvd;
            r_wb_rd    <= f_result(ONES, w_h_dvd, w_h_rem, w_h_negq, w_h_negr, 1'b0);
            r_wb_valid <= 1'b1;
            r_state    <= S_WB;
          end else if (w_h_dvd < w_h_dvs) begin
            r_saved_q  <= ZERO;
            r_saved_r  <= w_h_dvd;
            r_wb_rd    <= f_result(ZERO, w_h_dvd, w_h_rem, w_h_negq, w_h_negr, 1'b1);
            r_wb_valid <= 1'b1;
            r_state    <= S_WB;
          end else begin
            r_quo   <= w_h_dvd;
            r_rem   <= ZERO;
            r_cnt   <= CNT_W'(XLEN-1);
            r_state <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          r_quo <= w_quo_nx;
          r_rem <= w_rem_nx;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) begin
            r_saved_q  <= w_quo_nx;
            r_saved_r  <= w_rem_nx;
            r_wb_rd    <= f_result(w_quo_nx, w_rem_nx, r_is_rem, r_neg_q, r_neg_r, 1'b1);
            r_wb_valid <= 1'b1;
            r_state    <= S_WB;
          end
        end
        S_WB: if (wb_ready) begin
          r_wb_valid <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
